// File: rtl/niosqs_mul_pkg.sv
// niosqs_mul_pkg: shared op/state encodings, pass and latency constants, signed-correction helper
package niosqs_mul_pkg;
    typedef enum logic [1:0] {OP_MUL, OP_MULXUU, OP_MULXSU, OP_MULXSS} op_e;
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_RESP} state_e;
    localparam int MUL_PASSES = 4;
    localparam int MUL_LAT_LO = 3;
    localparam int MUL_LAT_HI = 6;
    // Unsigned high word minus this term gives the signed high word (mod 2^32).
    function automatic logic [31:0] corr_f(input op_e op, input logic [31:0] a, input logic [31:0] b);
        return ((op == OP_MULXSU || op == OP_MULXSS) && a[31] ? b : 32'd0)
             + ((op == OP_MULXSS) && b[31] ? a : 32'd0);
    endfunction
endpackage

// File: rtl/niosqs_nios2_qsys_0_mul_seq_if.sv
// niosqs_nios2_qsys_0_mul_seq_if: request/response handshake plus multiply-cell operand/result bus
// Signals: req_valid/req_ready/req_op/req_src1/req_src2, resp_valid/resp_ready/resp_data,
//          M_mul_src1/M_mul_src2 (to cell), M_mul_cell_result (from cell).
// Modports: slave = sequencer side, master = requester/cell side.
interface niosqs_nios2_qsys_0_mul_seq_if #(parameter int DATA_W = 32);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [DATA_W-1:0] req_src1;
    logic [DATA_W-1:0] req_src2;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic [DATA_W-1:0] M_mul_src1;
    logic [DATA_W-1:0] M_mul_src2;
    logic [DATA_W-1:0] M_mul_cell_result;
    modport slave (
        input  req_valid, req_op, req_src1, req_src2, resp_ready, M_mul_cell_result,
        output req_ready, resp_valid, resp_data, M_mul_src1, M_mul_src2
    );
    modport master (
        output req_valid, req_op, req_src1, req_src2, resp_ready, M_mul_cell_result,
        input  req_ready, resp_valid, resp_data, M_mul_src1, M_mul_src2
    );
endinterface

// File: rtl/niosqs_mul_seq_acc.sv
// niosqs_mul_seq_acc: 64-bit partial-product shift/add accumulator with final high-word/corr stage
// Ports: clk, reset_n (sync, active-low), clr_i (clear on accept), add_i (add prod_i at pass_i shift),
//        pass_i (0: <<0, 1/2: <<16, 3: <<32), prod_i (cell result), corr_i (signed correction),
//        hi_o = (acc + prod_i<<32)[63:32] - corr_i, valid while the last partial product is on prod_i.
module niosqs_mul_seq_acc
    import niosqs_mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr_i,
    input  logic              add_i,
    input  logic [1:0]        pass_i,
    input  logic [DATA_W-1:0] prod_i,
    input  logic [DATA_W-1:0] corr_i,
    output logic [DATA_W-1:0] hi_o
);
    logic [2*DATA_W-1:0] acc_q, acc_d, term;
    always_comb begin
        term  = {{DATA_W{1'b0}}, prod_i} << (pass_i == 2'd0 ? 0 : pass_i == 2'd3 ? DATA_W : DATA_W/2);
        acc_d = clr_i ? '0 : add_i ? acc_q + term : acc_q;
        // The final pass lands entirely in the high word, so only the upper half needs the add.
        hi_o  = acc_q[2*DATA_W-1:DATA_W] + prod_i - corr_i;
    end
    always_ff @(posedge clk) begin
        acc_q <= !reset_n ? '0 : acc_d;
    end
endmodule

// File: rtl/niosqs_nios2_qsys_0_mul_seq.sv
// niosqs_nios2_qsys_0_mul_seq: multiply sequencer driving the Nios II multiply cell (low word or high word via 4 passes)
// Ports: clk, reset_n (sync, active-low), bus (slave modport of niosqs_nios2_qsys_0_mul_seq_if).
// Config: MUL_SEQ_SIGNED_EN enables the signed correction for MULXSU/MULXSS; otherwise they equal MULXUU.
module niosqs_nios2_qsys_0_mul_seq
    import niosqs_mul_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input logic clk,
    input logic reset_n,
    niosqs_nios2_qsys_0_mul_seq_if.slave bus
);
    localparam int H = DATA_W / 2;
    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] corr, hi_word;
    logic              accept, hi, issue, acc_add;
    assign accept = state_q == S_IDLE && bus.req_valid;
    assign hi     = op_q != OP_MUL;
    assign issue  = state_q == S_ISSUE;
`ifdef MUL_SEQ_SIGNED_EN
    logic [DATA_W-1:0] corr_q, corr_d;
    always_comb corr_d = accept ? corr_f(op_e'(bus.req_op), bus.req_src1, bus.req_src2) : corr_q;
    always_ff @(posedge clk) corr_q <= !reset_n ? '0 : corr_d;
    assign corr = corr_q;
`else
    assign corr = '0;
`endif
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: if (accept) begin
                state_d = S_ISSUE;
                op_d    = op_e'(bus.req_op);
                a_d     = bus.req_src1;
                b_d     = bus.req_src2;
                cnt_d   = '0;
            end
            S_ISSUE: begin
                cnt_d   = cnt_q + 2'd1;
                state_d = (!hi || cnt_q == 2'(MUL_PASSES - 1)) ? S_DRAIN : S_ISSUE;
            end
            S_DRAIN: begin
                state_d = S_RESP;
                res_d   = hi ? hi_word : bus.M_mul_cell_result;
            end
            default: state_d = bus.resp_ready ? S_IDLE : S_RESP;
        endcase
    end
    // Pass n is issued with cnt_q == n; its product arrives one cycle later (cnt_q == n+1, or DRAIN for p3).
    always_comb begin
        bus.req_ready  = state_q == S_IDLE;
        bus.resp_valid = state_q == S_RESP;
        bus.resp_data  = res_q;
        bus.M_mul_src1 = !issue ? '0 : !hi ? a_q : {{H{1'b0}}, cnt_q[0] ? a_q[DATA_W-1:H] : a_q[H-1:0]};
        bus.M_mul_src2 = !issue ? '0 : !hi ? b_q : {{H{1'b0}}, cnt_q[1] ? b_q[DATA_W-1:H] : b_q[H-1:0]};
        acc_add        = issue && hi && cnt_q != 2'd0;
    end
    niosqs_mul_seq_acc #(.DATA_W(DATA_W)) u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr_i   (accept),
        .add_i   (acc_add),
        .pass_i  (cnt_q - 2'd1),
        .prod_i  (bus.M_mul_cell_result),
        .corr_i  (corr),
        .hi_o    (hi_word)
    );
endmodule

// File: tb/tb_niosqs_nios2_qsys_0_mul_seq.sv
// tb_niosqs_nios2_qsys_0_mul_seq: scoreboard bench with a registered multiply-cell model
module tb_niosqs_nios2_qsys_0_mul_seq;
    import niosqs_mul_pkg::*;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] s1_log[0:7];
    logic [31:0] s2_log[0:7];
    niosqs_nios2_qsys_0_mul_seq_if bus ();
    niosqs_nios2_qsys_0_mul_seq dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    always_ff @(posedge clk) bus.M_mul_cell_result <= bus.M_mul_src1 * bus.M_mul_src2;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = {32'd0, a};
        xb = {32'd0, b};
`ifdef MUL_SEQ_SIGNED_EN
        if (op[1]) xa = {{32{a[31]}}, a};
        if (op == 2'd3) xb = {{32{b[31]}}, b};
`endif
        p = xa * xb;
        return op == 2'd0 ? p[31:0] : p[63:32];
    endfunction
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int hold, input bit early);
        int lat;
        logic [31:0] held;
        for (int i = 0; i < 8; i++) begin
            s1_log[i] = 32'hDEADBEEF;
            s2_log[i] = 32'hDEADBEEF;
        end
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_src1  = a;
        bus.req_src2  = b;
        lat = 0;
        while (!bus.req_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.resp_ready = early;
        lat = 1;
        while (!bus.resp_valid && lat < 50) begin
            if (lat < 8) begin
                s1_log[lat] = bus.M_mul_src1;
                s2_log[lat] = bus.M_mul_src2;
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(op == 2'd0 ? MUL_LAT_LO : MUL_LAT_HI));
        held = bus.resp_data;
        chk("resp_data", held, exp_q.pop_front());
        if (!early) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_data", bus.resp_data, held);
                chk("hold_valid", 32'(bus.resp_valid), 32'd1);
                chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
            end
            bus.resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("req_ready_after", 32'(bus.req_ready), 32'd1);
        chk("valid_after", 32'(bus.resp_valid), 32'd0);
        bus.resp_ready = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
    initial begin
        bit seen;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_src1   = '0;
        bus.req_src2   = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_data", bus.resp_data, 32'd0);
        chk("rst_src1", bus.M_mul_src1, 32'd0);
        chk("rst_src2", bus.M_mul_src2, 32'd0);
        send(2'd0, 32'd7, 32'd6, 0, 1'b0);
        chk("mul_7x6_const", 32'h0000002A, model(2'd0, 32'd7, 32'd6));
        chk("mul_src1_c1", s1_log[1], 32'd7);
        chk("mul_src2_c1", s2_log[1], 32'd6);
        chk("mul_src1_c2", s1_log[2], 32'd0);
        send(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        send(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            chk("xuu_ff_src1", s1_log[i], 32'h0000FFFF);
            chk("xuu_ff_src2", s2_log[i], 32'h0000FFFF);
        end
        send(2'd1, 32'h12345678, 32'h9ABCDEF0, 0, 1'b0);
        chk("p0_src1", s1_log[1], 32'h00005678);
        chk("p0_src2", s2_log[1], 32'h0000DEF0);
        chk("p1_src1", s1_log[2], 32'h00001234);
        chk("p1_src2", s2_log[2], 32'h0000DEF0);
        chk("p2_src1", s1_log[3], 32'h00005678);
        chk("p2_src2", s2_log[3], 32'h00009ABC);
        chk("p3_src1", s1_log[4], 32'h00001234);
        chk("p3_src2", s2_log[4], 32'h00009ABC);
        chk("drain_src1", s1_log[5], 32'd0);
        send(2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
        send(2'd2, 32'h80000000, 32'h00000002, 0, 1'b0);
        send(2'd3, 32'h80000001, 32'h7FFFFFFF, 0, 1'b1);
        send(2'd2, 32'hFEDCBA98, 32'h89ABCDEF, 5, 1'b0);
        send(2'd0, 32'h0001FFFF, 32'h00030005, 2, 1'b1);
        for (int n = 0; n < 10; n++) begin
            send(2'($urandom_range(0, 3)), $urandom, $urandom, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        // Abort a MULXUU with reset in its second ISSUE cycle.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'd1;
        bus.req_src1  = 32'hFFFFFFFF;
        bus.req_src2  = 32'hFFFFFFFF;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort_in_issue", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen |= bus.resp_valid;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        send(2'd0, 32'd3, 32'd5, 0, 1'b0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
